// File: rtl/msk_and_hpc2_seq.sv
// Bit-serial sequencer feeding one external HPC2 masked AND gadget, one bit per issue slot.
// Define MSK_AND_SEQ_RND_STALL_EN to gate issue on rnd_valid; otherwise issue every RUN cycle.
module msk_and_hpc2_seq #(
  parameter int unsigned d = 2,
  parameter int unsigned W = 8,
  localparam int unsigned R  = d * (d - 1) / 2,
  localparam int unsigned KW = $clog2(W + 1),
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [W*d-1:0] i_in_a,
  input  logic [W*d-1:0] i_in_b,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [W*d-1:0] o_out_c,
  input  logic [R-1:0]   i_rnd_in,
  input  logic           i_rnd_valid,
  output logic           o_rnd_ready,
  output logic [d-1:0]   o_g_ina,
  output logic [d-1:0]   o_g_inb,
  output logic [R-1:0]   o_g_rnd,
  input  logic [d-1:0]   i_g_out
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                r_state;
  logic [KW-1:0]         r_k;
  logic [W-1:0][d-1:0]   r_a;
  logic [W-1:0][d-1:0]   r_b;
  logic [W-1:0][d-1:0]   r_c;
  logic                  r_v1;
  logic                  r_v2;
  logic [IW-1:0]         r_idx1;
  logic [IW-1:0]         r_idx2;

  logic                  w_issue;
  logic [IW-1:0]         w_kidx;

  assign w_kidx = r_k[IW-1:0];

`ifdef MSK_AND_SEQ_RND_STALL_EN
  assign w_issue = (r_state == StRun) && (r_k < KW'(W)) && i_rnd_valid;
`else
  logic w_rnd_valid_unused;
  assign w_rnd_valid_unused = i_rnd_valid;
  assign w_issue = (r_state == StRun) && (r_k < KW'(W));
`endif

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_out_c     = r_c;

  // Operand and random shares only leave the block inside their own issue/align slot.
  always_comb begin
    o_g_inb     = '0;
    o_g_rnd     = '0;
    o_rnd_ready = 1'b0;
    o_g_ina     = '0;
    if (w_issue) begin
      o_g_inb     = r_b[w_kidx];
      o_g_rnd     = i_rnd_in;
      o_rnd_ready = 1'b1;
    end
    if (r_v1) begin
      o_g_ina = r_a[r_idx1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_idx1  <= '0;
      r_idx2  <= '0;
    end else begin
      // Issue pipeline tracks which bit the gadget is working on in each stage.
      r_v1 <= w_issue;
      if (w_issue) begin
        r_idx1 <= w_kidx;
      end
      r_v2   <= r_v1;
      r_idx2 <= r_idx1;
      if (r_v2) begin
        r_c[r_idx2] <= i_g_out;
      end

      case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_a     <= i_in_a;
            r_b     <= i_in_b;
            r_k     <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (w_issue) begin
            r_k <= r_k + KW'(1);
            if (r_k == KW'(W - 1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          // No issue here, so both stages are empty after this edge once stage 1 is.
          if (!r_v1) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_msk_and_hpc2_seq.sv
// Self-checking bench for msk_and_hpc2_seq: d=2 and d=3 instances, each with a behavioural HPC2.
module tb_msk_and_hpc2_seq;
  localparam int unsigned W  = 8;
  localparam int unsigned D2 = 2;
  localparam int unsigned R2 = 1;
  localparam int unsigned D3 = 3;
  localparam int unsigned R3 = 3;
`ifdef MSK_AND_SEQ_RND_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              iv2, ir2, ov2, ordy2, rv2, rr2;
  logic [W*D2-1:0]   a2, b2, c2;
  logic [R2-1:0]     rnd2, grnd2;
  logic [D2-1:0]     gina2, ginb2;
  logic [D2-1:0]     gout2 = '0;

  logic              iv3, ir3, ov3, ordy3, rv3, rr3;
  logic [W*D3-1:0]   a3, b3, c3;
  logic [R3-1:0]     rnd3, grnd3;
  logic [D3-1:0]     gina3, ginb3;
  logic [D3-1:0]     gout3 = '0;

  int n_cmp = 0;
  int n_err = 0;
  bit pend = 1'b0;

  msk_and_hpc2_seq #(.d(D2), .W(W)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv2), .o_in_ready(ir2), .i_in_a(a2),
    .i_in_b(b2), .o_out_valid(ov2), .i_out_ready(ordy2), .o_out_c(c2), .i_rnd_in(rnd2),
    .i_rnd_valid(rv2), .o_rnd_ready(rr2), .o_g_ina(gina2), .o_g_inb(ginb2), .o_g_rnd(grnd2),
    .i_g_out(gout2)
  );

  msk_and_hpc2_seq #(.d(D3), .W(W)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv3), .o_in_ready(ir3), .i_in_a(a3),
    .i_in_b(b3), .o_out_valid(ov3), .i_out_ready(ordy3), .o_out_c(c3), .i_rnd_in(rnd3),
    .i_rnd_valid(rv3), .o_rnd_ready(rr3), .o_g_ina(gina3), .o_g_inb(ginb3), .o_g_rnd(grnd3),
    .i_g_out(gout3)
  );

  // HPC2 output shares: c_i = a_i b_i ^ sum_{j!=i} (~a_i r_ij) ^ a_i (b_j ^ r_ij).
  function automatic logic [2:0] hpc2(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] r, input int dd);
    logic [2:0] c;
    int lo, hi, idx;
    logic rij;
    c = '0;
    for (int i = 0; i < dd; i++) begin
      c[i] = a[i] & b[i];
      for (int j = 0; j < dd; j++) begin
        if (j != i) begin
          lo  = (i < j) ? i : j;
          hi  = (i < j) ? j : i;
          idx = lo * dd - lo * (lo + 1) / 2 + (hi - lo - 1);
          rij = r[idx];
          c[i] = c[i] ^ ((~a[i]) & rij) ^ (a[i] & (b[j] ^ rij));
        end
      end
    end
    return c;
  endfunction

  // Gadget models: b/rnd latched at issue, a one cycle later, result visible the cycle after.
  logic [D2-1:0] gb2 = '0;
  logic [R2-1:0] gr2 = '0;
  logic [2:0]    gt2;
  always @(posedge clk) begin
    gt2 = hpc2({1'b0, gina2}, {1'b0, gb2}, {2'b00, gr2}, D2);
    gb2 <= ginb2;
    gr2 <= grnd2;
    gout2 <= gt2[D2-1:0];
  end

  logic [D3-1:0] gb3 = '0;
  logic [R3-1:0] gr3 = '0;
  logic [2:0]    gt3;
  always @(posedge clk) begin
    gt3 = hpc2(gina3, gb3, gr3, D3);
    gb3 <= ginb3;
    gr3 <= grnd3;
    gout3 <= gt3;
  end

  function automatic logic [W*D2-1:0] share2(input logic [W-1:0] v);
    logic [W*D2-1:0] s;
    logic m;
    for (int i = 0; i < W; i++) begin
      m = 1'($urandom);
      s[i*D2]   = m;
      s[i*D2+1] = v[i] ^ m;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] unmask2(input logic [W*D2-1:0] s);
    logic [W-1:0] u;
    for (int i = 0; i < W; i++) u[i] = s[i*D2] ^ s[i*D2+1];
    return u;
  endfunction

  function automatic logic [W*D3-1:0] share3(input logic [W-1:0] v);
    logic [W*D3-1:0] s;
    logic m0, m1;
    for (int i = 0; i < W; i++) begin
      m0 = 1'($urandom);
      m1 = 1'($urandom);
      s[i*D3]   = m0;
      s[i*D3+1] = m1;
      s[i*D3+2] = v[i] ^ m0 ^ m1;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] unmask3(input logic [W*D3-1:0] s);
    logic [W-1:0] u;
    for (int i = 0; i < W; i++) u[i] = s[i*D3] ^ s[i*D3+1] ^ s[i*D3+2];
    return u;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge while the d=2 DUT is idle; returns likewise.
  task automatic op2(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [63:0] stalls,
                     input int hold, input bit b2b, input logic [W-1:0] na,
                     input logic [W-1:0] nb);
    int cyc, lat, nrr, nviol, nrdy, nstall;
    logic [W*D2-1:0] snap;
    if (!pend) begin
      a2 = share2(va);
      b2 = share2(vb);
    end
    pend = 1'b0;
    iv2 = 1'b1;
    chk("in_ready_idle", ir2, 1);
    @(posedge clk);
    @(negedge clk);
    if (b2b) begin
      a2 = share2(na);
      b2 = share2(nb);
      pend = 1'b1;
    end else begin
      iv2 = 1'b0;
    end
    cyc = 1; lat = -1; nrr = 0; nviol = 0; nrdy = 0;
    nstall = $countones(stalls);
    while (lat < 0 && cyc < 60) begin
      rv2  = !stalls[cyc];
      rnd2 = R2'($urandom);
      #1;
      if (ov2) begin
        lat = cyc;
      end else begin
        if (rr2) nrr++;
        if (!rr2 && (ginb2 != '0 || grnd2 != '0)) nviol++;
        if (StallEn && rr2 && !rv2) nviol++;
        if (ir2) nrdy++;
        @(negedge clk);
        cyc++;
      end
    end
    rv2 = 1'b1;
    chk("out_valid_latency", lat, W + 3 + (StallEn ? nstall : 0));
    chk("rnd_ready_count", nrr, W);
    chk("no_share_outside_slot", nviol, 0);
    chk("in_ready_low_busy", nrdy, 0);
    chk("result_a_and_b", unmask2(c2), va & vb);
    snap = c2;
    nviol = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      if (c2 !== snap || ov2 !== 1'b1 || ir2 !== 1'b0) nviol++;
    end
    if (hold > 0) chk("done_hold_stable", nviol, 0);
    ordy2 = 1'b1;
    @(negedge clk);
    ordy2 = 1'b0;
    #1;
    chk("in_ready_after_hs", ir2, 1);
    chk("out_valid_after_hs", ov2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] x, y, x2, y2;
    int cyc, lat, nrr;
    iv2 = 0; ordy2 = 0; rv2 = 0; rnd2 = '0; a2 = '0; b2 = '0;
    iv3 = 0; ordy3 = 0; rv3 = 1; rnd3 = '0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", ir2, 1);
    chk("rst_out_valid", ov2, 0);
    chk("rst_out_c", c2, 0);
    chk("rst_rnd_ready", rr2, 0);
    chk("rst_g_ina", gina2, 0);
    chk("rst_g_inb", ginb2, 0);
    chk("rst_g_rnd", grnd2, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++) begin
      x = W'($urandom);
      y = W'($urandom);
      op2(x, y, 64'd0, 0, 1'b0, '0, '0);
    end

    // rnd_valid low in three scattered RUN cycles
    x = W'($urandom);
    y = W'($urandom);
    op2(x, y, (64'd1 << 2) | (64'd1 << 5) | (64'd1 << 7), 0, 1'b0, '0, '0);

    // consumer stalls five cycles in DONE
    x = W'($urandom);
    y = W'($urandom);
    op2(x, y, 64'd0, 5, 1'b0, '0, '0);

    // d=3: 0xFF & 0xA5
    a3 = share3(8'hFF);
    b3 = share3(8'hA5);
    iv3 = 1'b1;
    chk("d3_in_ready_idle", ir3, 1);
    @(posedge clk);
    @(negedge clk);
    iv3 = 1'b0;
    cyc = 1; lat = -1; nrr = 0;
    while (lat < 0 && cyc < 60) begin
      rnd3 = R3'($urandom);
      #1;
      if (ov3) begin
        lat = cyc;
      end else begin
        if (rr3) nrr++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("d3_latency", lat, W + 3);
    chk("d3_rnd_ready_count", nrr, W);
    chk("d3_result", unmask3(c3), 8'hA5);
    ordy3 = 1'b1;
    @(negedge clk);
    ordy3 = 1'b0;
    #1;
    chk("d3_in_ready_after_hs", ir3, 1);

    // reset asserted mid-RUN while k=4
    x = W'($urandom);
    y = W'($urandom);
    a2 = share2(x);
    b2 = share2(y);
    iv2 = 1'b1;
    rv2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_run_issuing", rr2, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", ir2, 1);
    chk("mid_rst_out_valid", ov2, 0);
    chk("mid_rst_out_c", c2, 0);
    chk("mid_rst_rnd_ready", rr2, 0);
    chk("mid_rst_g_ina", gina2, 0);
    chk("mid_rst_g_inb", ginb2, 0);
    chk("mid_rst_g_rnd", grnd2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    x = W'($urandom);
    y = W'($urandom);
    op2(x, y, 64'd0, 0, 1'b0, '0, '0);

    // back-to-back: second word waits for the first output handshake
    x  = W'($urandom);
    y  = W'($urandom);
    x2 = W'($urandom);
    y2 = W'($urandom);
    op2(x, y, 64'd0, 2, 1'b1, x2, y2);
    op2(x2, y2, 64'd0, 0, 1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msk_and_hpc2_seq.md
# msk_and_hpc2_seq

Bit-serial sequencer that computes the share-wise masked AND of two `W`-bit masked words using a single external HPC2 masked AND gadget instance. It accepts one pair of `d`-share words per valid/ready handshake and issues one bit per cycle into the gadget. It respects the gadget's input latencies: `inb` and randomness at issue, `ina` one cycle later, output two cycles after issue. It collects the result bits into a `d`-share output word. It sits between a masked round datapath and a shared HPC2 AND, letting area-constrained S-box implementations reuse one gadget.

## Interface
- `d`, 2: number of shares.
- `W`, 8: bits per word.
- Derived: `R = d*(d-1)/2`, fresh random bits per gadget evaluation.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand word pair valid.
- `in_ready`  out  1  sequencer can accept an operand pair.
- `in_a`  in  W*d  masked operand A; share `j` of bit `i` is at index `i*d+j`.
- `in_b`  in  W*d  masked operand B; same layout as `in_a`.
- `out_valid`  out  1  result word valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_c`  out  W*d  masked result, A AND B, same layout as `in_a`.
- `rnd_in`  in  R  fresh randomness from the PRNG.
- `rnd_valid`  in  1  `rnd_in` is fresh.
- `rnd_ready`  out  1  randomness consumed this cycle.
- `g_ina`  out  d  to gadget `ina`; latency 1 relative to issue.
- `g_inb`  out  d  to gadget `inb`; latency 0.
- `g_rnd`  out  R  to gadget `rnd`; latency 0.
- `g_out`  in  d  from gadget `out`; valid 2 cycles after issue.

## Operation
- States: `IDLE`, `RUN`, `DRAIN`, `DONE`.
- `IDLE`:
  - `in_ready`=1.
  - On `in_valid & in_ready`: register `in_a` and `in_b` into operand registers, clear issue counter `k`, go to `RUN`.
- `RUN`:
  - `issue = rnd_valid` when `MSK_AND_SEQ_RND_STALL_EN` is defined; otherwise `issue = 1`.
  - On issue:
    - `g_inb` = B bit `k` shares.
    - `g_rnd` = `rnd_in`.
    - `rnd_ready`=1.
    - Push `{valid=1, idx=k}` into a 2-stage issue pipeline.
    - `k` increments.
  - After issuing bit `W-1`, go to `DRAIN`.
- `ina` alignment:
  - Each cycle, if pipeline stage 1 is valid, `g_ina` = A bit `idx1` shares; otherwise 0.
  - This holds regardless of the current state.
- Capture:
  - Each cycle, if stage 2 is valid, write `g_out` into `out_c` bit `idx2` shares.
- `DRAIN`:
  - Go to `DONE` once both pipeline stages are empty after the capture.
- `DONE`:
  - `out_valid`=1; `out_c` is held stable.
  - On `out_ready`, go to `IDLE`.
- `g_inb`, `g_rnd` and `rnd_ready` are 0 in every non-issue cycle. No operand or random share is ever presented outside its issue slot.
- Shares are never recombined. Each share moves only through a mux or register indexed by its own share index.
- Randomness:
  - Exactly `W` random words are consumed per operation.
  - A random word is never reused.
- `k` width is `$clog2(W+1)`. `k` never wraps; it saturates at `W` until the next accept.
- Reset mid-operation:
  - State returns to `IDLE`; pipeline valids, `k`, `out_c` and all operand registers clear to 0.
  - The gadget's internal registers are flushed implicitly: results in flight are ignored because their valids are cleared.

## Timing
- Reset values:
  - `in_ready`=1 (IDLE).
  - `out_valid`=0, `out_c`=0.
  - `rnd_ready`=0, `g_ina`=0, `g_inb`=0, `g_rnd`=0.
- Accept at edge of cycle 0.
- Bit `k` (no stalls):
  - Issued in cycle `k+1`.
  - `g_ina` driven in cycle `k+2`.
  - `g_out` sampled at end of cycle `k+3`.
- `out_valid` rises in cycle `W+3` after accept, i.e. `W+3` cycles of latency with no stalls.
- Each `RUN` cycle with `rnd_valid`=0 (macro defined) adds exactly one cycle of latency.
- `in_ready` is low from accept until the cycle after the `out_valid & out_ready` handshake. There is no overlap of operations; throughput is one word per `W+4` cycles minimum.
- `out_c` and `out_valid` hold under `out_ready`=0 indefinitely.

## Configuration
- `MSK_AND_SEQ_RND_STALL_EN`:
  - Defined: issue is gated by `rnd_valid`. Stall cycles present zeros to the gadget and are tracked by the pipeline valids.
  - Undefined: `rnd_valid` is ignored, and randomness is treated as fresh every cycle. `RUN` lasts exactly `W` cycles.

## Test plan
- Reset, then drive random unmasked `a`, `b` with `d`=2, `W`=8 -> `out_valid` in cycle 11 after accept; the XOR of `out_c` shares equals `a & b`.
- `a`=0xFF, `b`=0xA5 with random sharings, `d`=3 -> unmasked result 0xA5; `rnd_ready` high for exactly 8 cycles.
- Macro defined, `rnd_valid` low in 3 scattered `RUN` cycles -> correct result; `out_valid` at cycle 14; no `rnd_in` value consumed twice.
- `out_ready` held low 5 cycles in `DONE` -> `out_c` stable and `in_ready`=0 throughout; accepted after release.
- Assert `rst_n` low during `RUN` at `k`=4 -> all outputs at reset values immediately; next operation returns the correct result with no stale bits.
- Back-to-back `in_valid` -> second word accepted only after the first output handshake; both results correct.
